// File: rtl/ring_frc_from_remote_receiver.sv
// Receive stage for remote force packets on the ring: source check, FIFO buffering,
// first-word-fall-through output register and per-source end-of-iteration tracking.
module ring_frc_from_remote_receiver #(
    parameter int unsigned FLOAT_WIDTH          = 32,
    parameter int unsigned GLOBAL_CELL_ID_WIDTH = 3,
    parameter int unsigned PARTICLE_ID_WIDTH    = 7,
    parameter int unsigned NODE_ID_WIDTH        = 3,
    parameter int unsigned NUM_REMOTE_SRC_NODES = 3,
    parameter int unsigned FIFO_DEPTH           = 16,
    parameter int unsigned PKT_W = 3*FLOAT_WIDTH + 3*GLOBAL_CELL_ID_WIDTH + PARTICLE_ID_WIDTH
                                   + NODE_ID_WIDTH + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NODE_ID_WIDTH-1:0]          i_init_id,
    input  logic                              i_iter_start,
    input  logic [PKT_W-1:0]                  i_axis_tdata,
    input  logic                              i_axis_tvalid,
    input  logic                              i_axis_tlast,
    output logic                              o_axis_tready,
    output logic [3*FLOAT_WIDTH-1:0]          o_frc,
    output logic [3*GLOBAL_CELL_ID_WIDTH-1:0] o_frc_gcid,
    output logic [PARTICLE_ID_WIDTH-1:0]      o_frc_parid,
    output logic                              o_frc_valid,
    input  logic                              i_frc_ready,
    output logic                              o_all_remote_frc_received,
    output logic [15:0]                       o_rx_count,
    output logic                              o_err
);

    localparam int unsigned ENTRY_W = 3*FLOAT_WIDTH + 3*GLOBAL_CELL_ID_WIDTH + PARTICLE_ID_WIDTH;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = AW + 1;
    localparam int unsigned NSRC    = NUM_REMOTE_SRC_NODES;

    // Packet fields; force, gcid and parid are contiguous from the LSB, so one slice is the FIFO entry
    logic [ENTRY_W-1:0]       pkt_entry;
    logic [NODE_ID_WIDTH-1:0] pkt_src;
    logic                     pkt_empty;
    logic [NODE_ID_WIDTH-1:0] src_offset;
    logic                     src_legal;

    assign pkt_entry  = i_axis_tdata[ENTRY_W-1:0];
    assign pkt_src    = i_axis_tdata[ENTRY_W +: NODE_ID_WIDTH];
    assign pkt_empty  = i_axis_tdata[PKT_W-1];
    assign src_offset = pkt_src - i_init_id;
    assign src_legal  = (src_offset != '0) && (32'(src_offset) <= NSRC);

    logic accept;
    logic wr_en;
    logic rd_en;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_next;

    assign accept = i_axis_tvalid && o_axis_tready;
    assign wr_en  = accept && src_legal && !pkt_empty;
    assign rd_en  = (count_q != '0) && (!o_frc_valid || i_frc_ready);

    always_comb begin
        count_next = count_q;
        if (wr_en && !rd_en) begin
            count_next = count_q + CNT_W'(1);
        end else if (!wr_en && rd_en) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    // Storage array carries no reset; pointers and occupancy define its validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= pkt_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            o_axis_tready <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count_q       <= count_next;
            o_axis_tready <= (count_next < CNT_W'(FIFO_DEPTH));
        end
    end

    // Output register: reloads from the FIFO head on the handshake cycle for 1/cycle throughput
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_frc_valid <= 1'b0;
            o_frc       <= '0;
            o_frc_gcid  <= '0;
            o_frc_parid <= '0;
        end else if (rd_en) begin
            o_frc_valid                          <= 1'b1;
            {o_frc_parid, o_frc_gcid, o_frc}     <= mem[rd_ptr];
        end else if (i_frc_ready) begin
            o_frc_valid <= 1'b0;
        end
    end

    logic [NSRC-1:0] done_q;
    logic [NSRC-1:0] done_hit;
    logic [NSRC-1:0] done_base;
    logic [NSRC-1:0] done_next;
    logic            err_base;
    logic            err_next;
    logic [15:0]     rx_base;
    logic [15:0]     rx_next;

    always_comb begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            done_hit[i] = (32'(src_offset) == i + 1);
        end
    end

    // Iteration clear is applied first so a coincident packet lands in the new iteration
    always_comb begin
        done_base = i_iter_start ? '0 : done_q;
        err_base  = i_iter_start ? 1'b0 : o_err;
        rx_base   = i_iter_start ? 16'd0 : o_rx_count;
        done_next = done_base;
        err_next  = err_base;
        rx_next   = rx_base;
        if (accept) begin
            if (!src_legal) begin
                err_next = 1'b1;
            end else begin
                if (i_axis_tlast) begin
                    if ((done_base & done_hit) != '0) err_next = 1'b1;
                    done_next = done_base | done_hit;
                end
                if (!pkt_empty && (rx_base != 16'hFFFF)) begin
                    rx_next = rx_base + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q                    <= '0;
            o_err                     <= 1'b0;
            o_rx_count                <= 16'd0;
            o_all_remote_frc_received <= 1'b0;
        end else begin
            done_q                    <= done_next;
            o_err                     <= err_next;
            o_rx_count                <= rx_next;
            o_all_remote_frc_received <= !i_iter_start && (&done_q) && (count_q == '0) && !o_frc_valid;
        end
    end

endmodule

// File: doc/ring_frc_from_remote_receiver.md
# ring_frc_from_remote_receiver

Receive-side stage for remote force traffic on the inter-FPGA ring. It accepts AXI-Stream force packets that arrive from the remote force-send controllers of other nodes and checks where each one came from. It buffers them in a small FIFO and presents one force at a time to the local force accumulation path. It also tracks per-source end-of-stream markers so the node knows when every remote contribution for the current iteration has arrived.

## Interface
Parameters:
- FLOAT_WIDTH, 32, width of one force component
- GLOBAL_CELL_ID_WIDTH, 3, per-axis cell id width
- PARTICLE_ID_WIDTH, 7, particle id width
- NODE_ID_WIDTH, 3, node id width
- NUM_REMOTE_SRC_NODES, 3, number of upstream nodes whose forces this node receives
- FIFO_DEPTH, 16, buffer entries (power of two, ≥ 4)
- PKT_W, 3*FLOAT_WIDTH+3*GLOBAL_CELL_ID_WIDTH+PARTICLE_ID_WIDTH+NODE_ID_WIDTH+1, packet payload width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_init_id  in  NODE_ID_WIDTH  this node's id, static after reset
- i_iter_start  in  1  one-cycle pulse, starts a new iteration
- i_axis_tdata  in  PKT_W  bit fields, LSB first:
  - frc x, y, z (3*FLOAT_WIDTH)
  - gcid (3*GLOBAL_CELL_ID_WIDTH)
  - parid (PARTICLE_ID_WIDTH)
  - src node id (NODE_ID_WIDTH)
  - empty bit (MSB)
- i_axis_tvalid  in  1  packet valid
- i_axis_tlast  in  1  last packet from this source for the iteration
- o_axis_tready  out  1  ready to accept
- o_frc  out  3*FLOAT_WIDTH  force to local accumulator
- o_frc_gcid  out  3*GLOBAL_CELL_ID_WIDTH  target cell
- o_frc_parid  out  PARTICLE_ID_WIDTH  target particle
- o_frc_valid  out  1  output valid
- i_frc_ready  in  1  accumulator ready
- o_all_remote_frc_received  out  1  every source done, and the block is drained
- o_rx_count  out  16  non-empty forces accepted this iteration
- o_err  out  1  sticky protocol error

## Operation
- **Accept rule:** a packet is accepted when i_axis_tvalid & o_axis_tready. o_axis_tready = (FIFO occupancy < FIFO_DEPTH), computed from registered state only; it never depends on tvalid.
- **Source offset:**
  - offset = (src − i_init_id) mod 2^NODE_ID_WIDTH.
  - Legal offsets are 1..NUM_REMOTE_SRC_NODES.
  - An illegal offset: the packet is accepted (consumed), not written to the FIFO, and o_err is set.
- **Write rule:** non-empty packets with a legal source are written to the FIFO (force, gcid, parid) and o_rx_count is incremented. o_rx_count saturates at 16'hFFFF.
- **Empty packets** (empty bit = 1) are never forwarded and never counted. They exist so a source with zero forces can still send tlast.
- **Done bits:** accepting a packet with tlast and a legal source sets done[offset−1].
  - If that done bit is already set, o_err is set and the bit stays 1.
  - tlast on an illegal source only sets o_err.
- **Output stage:**
  - A registered output holds the FIFO head (first-word fall-through).
  - o_frc_valid stays high, with data stable, until i_frc_ready.
  - A new head loads on the same cycle as the handshake, so back-to-back transfers run at 1 per cycle.
- **Completion:** o_all_remote_frc_received = all done bits set & FIFO empty & !o_frc_valid, registered.
- **i_iter_start clears** the done bits, o_rx_count and o_err. It does not flush the FIFO or the output register.
- **i_iter_start coincident with an accepted packet:** the clear applies first, then the packet's effects (count, done, err) apply. The packet belongs to the new iteration.
- **Simultaneous FIFO write and read:** occupancy is unchanged. A write into a full FIFO cannot occur, because ready was low.

## Timing
- Reset (rst = 0, asynchronous) sets:
  - o_axis_tready = 0, then 1 on the first clk edge after release
  - o_frc_valid = 0
  - o_frc, o_frc_gcid, o_frc_parid = 0
  - o_all_remote_frc_received = 0
  - o_rx_count = 0
  - o_err = 0
  - FIFO pointers and done bits cleared
- Latency: a packet accepted at edge N, into an empty FIFO with the output idle, drives o_frc_valid = 1 after edge N+1.
- o_all_remote_frc_received rises one cycle after its condition becomes true. It falls on the edge that registers i_iter_start.
- Reset mid-stream discards all buffered forces. The upstream stream must be restarted by the system.
- Sustained throughput is 1 packet/cycle when i_frc_ready is held high.

## Test plan
- **Single stream.**
  - Stimulus: i_init_id = 0; src = 1 sends 4 forces, x = 32'h3f800000, gcid = 9'b010010010, parid 0..3, tlast on the last; i_frc_ready = 1.
  - Required: 4 outputs in order, each 1 cycle after its acceptance; o_rx_count = 4; o_all_remote_frc_received stays 0 (src 2 and 3 not done).
- **All sources done.**
  - Stimulus: src 1, 2 and 3 each end with tlast; src 3 sends a single empty tlast packet.
  - Required: done all set; o_all_remote_frc_received = 1 only after the last output handshake; the empty packet is never output.
- **Backpressure.**
  - Stimulus: i_frc_ready = 0; 20 packets offered back-to-back.
  - Required: o_axis_tready drops after 16 accepted, plus 1 more held in the output register; output data stays stable; releasing ready drains all 17 in order with no loss.
- **Errors.**
  - Stimulus: packet with src = i_init_id (offset 0); then a second tlast from src 1.
  - Required: both packets consumed without output; o_err = 1, sticky until i_iter_start.
- **Iteration boundary.**
  - Stimulus: i_iter_start on the same cycle as an accepted tlast packet from src 2.
  - Required: afterwards o_rx_count = 1, done = 3'b010, o_err = 0.
- **Async reset.**
  - Stimulus: drop rst with 5 entries buffered, between clock edges.
  - Required: all outputs reach their reset values immediately, without waiting for a clk edge.
